alu_muldiv_seq: RTL and testbench

- Multi-cycle sequencer for unsigned multiply and divide operations: MUL, MULHU, DIVU, REMU.
- Does not contain its own adder. It reuses the shared 32-bit ALU by driving the ALU's operand and opcode inputs, one iteration per cycle.
- Sits beside the EX stage. The pipeline stalls on `busy` and takes `result` when `done` pulses.
- Bit-serial: DATA_WIDTH iterations per operation, with shifts and compare done locally.

---
 rtl/alu_muldiv_seq.sv | 114 +++++++++++
 tb/tb_alu_muldiv_seq.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
// Bit-serial unsigned multiply/divide sequencer (MUL, MULHU, DIVU, REMU).
// Borrows the shared pipeline ALU for its add/subtract, one iteration per cycle.
module alu_muldiv_seq #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [1:0]               funct,
    input  logic [DATA_WIDTH-1:0]    op_a,
    input  logic [DATA_WIDTH-1:0]    op_b,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_WIDTH-1:0]    result,
    output logic [DATA_WIDTH-1:0]    alu_srca,
    output logic [DATA_WIDTH-1:0]    alu_srcb,
    output logic [OPCODE_LENGTH-1:0] alu_op,
    input  logic [DATA_WIDTH-1:0]    alu_result
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(4'b0011);
    localparam logic [1:0] F_DIVU = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                state;
    logic [1:0]            fq;
    logic [DATA_WIDTH-1:0] acc;   // hi (multiply) / rem (divide)
    logic [DATA_WIDTH-1:0] low;   // lo (multiply) / quo (divide)
    logic [DATA_WIDTH-1:0] opnd;  // mcand (multiply) / dvs (divide)
    logic [CW-1:0]         cnt;

    logic [DATA_WIDTH-1:0] acc_nxt, low_nxt, div_r;
    logic                  div_take, mul_c, last;

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);
    assign last = (cnt == CW'(DATA_WIDTH - 1));

    assign div_r    = {acc[DATA_WIDTH-2:0], low[DATA_WIDTH-1]};
    // A set msb means the true remainder already exceeds any 32-bit divisor.
    assign div_take = acc[DATA_WIDTH-1] || (div_r >= opnd);
    assign mul_c    = (alu_result < acc);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        alu_srca = '0;
        alu_srcb = '0;
        alu_op   = OP_ADD;
        acc_nxt  = acc;
        low_nxt  = low;
        if (state == S_RUN) begin
            if (fq[1]) begin
                alu_srca = div_r;
                alu_srcb = opnd;
                alu_op   = OP_SUB;
                acc_nxt  = div_take ? alu_result : div_r;
                low_nxt  = {low[DATA_WIDTH-2:0], div_take};
            end else begin
                alu_srca = acc;
                alu_srcb = low[0] ? opnd : '0;
                acc_nxt  = {mul_c, alu_result[DATA_WIDTH-1:1]};
                low_nxt  = {alu_result[0], low[DATA_WIDTH-1:1]};
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            fq     <= '0;
            acc    <= '0;
            low    <= '0;
            opnd   <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    acc <= acc_nxt;
                    low <= low_nxt;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        state  <= S_DONE;
                        result <= fq[0] ? acc_nxt : low_nxt;
                    end
                end
                default: begin
                    if (start) begin
                        fq   <= funct;
                        acc  <= '0;
                        low  <= op_a;
                        opnd <= op_b;
                        cnt  <= '0;
                        // Divide by zero resolves immediately with RISC-V results.
                        if (funct[1] && (op_b == '0)) begin
                            state  <= S_DONE;
                            result <= (funct == F_DIVU) ? '1 : op_a;
                        end else begin
                            state <= S_RUN;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed self-checking bench for alu_muldiv_seq with a behavioural stand-in for the shared ALU.
module tb_alu_muldiv_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  funct;
    logic [31:0] op_a, op_b;
    logic        busy, done;
    logic [31:0] result, alu_srca, alu_srcb, alu_result;
    logic [3:0]  alu_op;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_muldiv_seq #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .funct(funct),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result),
        .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_op(alu_op),
        .alu_result(alu_result)
    );

    // Shared ALU: ADD and SUB are the only operations the sequencer uses.
    always_comb begin
        alu_result = '0;
        if (alu_op == 4'b0010)      alu_result = alu_srca + alu_srcb;
        else if (alu_op == 4'b0011) alu_result = alu_srca - alu_srcb;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one operation and follow it to completion; optionally pulse a stray start at RUN cycle poke_n.
    task automatic do_op(input string tag, input logic [1:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input int exp_lat, input int poke_n);
        int n = 0;
        int busy_n = 0;
        int op_bad = 0;
        logic [3:0] exp_op;
        logic [31:0] held;
        exp_op = f[1] ? 4'b0011 : 4'b0010;
        @(negedge clk);
        start = 1'b1; funct = f; op_a = a; op_b = b;
        @(negedge clk);
        start = 1'b0; n = 1;
        while (!done && n < 100) begin
            if (busy) busy_n++;
            if (busy && alu_op !== exp_op) op_bad++;
            if (n == poke_n) begin
                start = 1'b1; funct = 2'b00; op_a = 32'd99; op_b = 32'd77;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check({tag, "_result"}, result, exp_res);
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_lat - 1));
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        check({tag, "_aluop_bad_cycles"}, 32'(op_bad), 32'd0);
        held = result;
        @(negedge clk);
        check({tag, "_done_drop"}, {31'd0, done}, 32'd0);
        check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_result_held"}, result, exp_res);
        check({tag, "_result_stable"}, result, held);
    endtask

    initial begin
        int n;
        int dones;
        reset = 1'b1; start = 1'b0; funct = 2'b00; op_a = '0; op_b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_srca", alu_srca, 32'd0);
        check("rst_srcb", alu_srcb, 32'd0);
        check("rst_aluop", {28'd0, alu_op}, 32'h2);
        reset = 1'b0;
        @(negedge clk);
        check("idle_aluop", {28'd0, alu_op}, 32'h2);
        check("idle_srca", alu_srca, 32'd0);
        check("idle_srcb", alu_srcb, 32'd0);

        do_op("mul_7x6",    2'b00, 32'd7,          32'd6,          32'h0000002A, 33, -1);
        do_op("mul_ff",     2'b00, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001, 33, -1);
        do_op("mulhu_ff",   2'b01, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE, 33, -1);
        do_op("divu_100_7", 2'b10, 32'd100,        32'd7,          32'd14,       33, -1);
        do_op("remu_100_7", 2'b11, 32'd100,        32'd7,          32'd2,        33, -1);
        do_op("divu_max_1", 2'b10, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF, 33, -1);
        do_op("divu_msb",   2'b10, 32'h80000000,   32'hFFFFFFFF,   32'h00000000, 33, -1);
        do_op("divu_by0",   2'b10, 32'd5,          32'd0,          32'hFFFFFFFF, 1,  -1);
        do_op("remu_by0",   2'b11, 32'd5,          32'd0,          32'd5,        1,  -1);
        do_op("start_in_run", 2'b00, 32'h1234,     32'h10,         32'h00012340, 33, 5);

        // Reset mid-RUN aborts the operation with no done pulse.
        @(negedge clk);
        start = 1'b1; funct = 2'b00; op_a = 32'hFFFF; op_b = 32'hFFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_result", result, 32'd0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        do_op("mul_3x3", 2'b00, 32'd3, 32'd3, 32'd9, 33, -1);

        // Back-to-back: REMU issued in the DIVU done cycle.
        @(negedge clk);
        start = 1'b1; funct = 2'b10; op_a = 32'd9; op_b = 32'd2;
        @(negedge clk);
        start = 1'b0; n = 1;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("b2b_first_latency", 32'(n), 32'd33);
        check("b2b_first_result", result, 32'd4);
        start = 1'b1; funct = 2'b11; op_a = 32'd9; op_b = 32'd2;
        @(negedge clk);
        start = 1'b0; n = 1;
        check("b2b_no_idle", {31'd0, busy}, 32'd1);
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("b2b_done_spacing", 32'(n), 32'd33);
        check("b2b_second_result", result, 32'd1);
        @(negedge clk);
        check("b2b_final_idle", {30'd0, busy, done}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
